// File: rtl/cam_capture.sv
// cam_capture: oversampled DVP camera capture into an RGB565 pixel FIFO stream.
// Ports: PCLK/PRESET clock+reset, cap_en enable, cam_pclk/cam_vsync/cam_href/cam_data
//   DVP inputs, pix_data/pix_sof/pix_eol/pix_valid/pix_ready output stream,
//   busy, frame_done pulse, sticky overflow. Define CAM_CAPTURE_STATS_EN to add
//   line_count/pixel_count outputs.
module cam_capture #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        cap_en,
  input  logic        cam_pclk,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [15:0] pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow
`ifdef CAM_CAPTURE_STATS_EN
  ,
  output logic [11:0] line_count,
  output logic [11:0] pixel_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VSYNC,
    WAIT_FRAME,
    ACTIVE
  } state_t;

  // {pclk, vsync, href, data}
  logic [10:0] sync_q [SYNC_STAGES];
  logic [2:0]  last_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      last_q <= '0;
    end else begin
      sync_q[0] <= {cam_pclk, cam_vsync, cam_href, cam_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      last_q <= sync_q[SYNC_STAGES-1][10:8];
    end
  end

  logic [10:0] s;
  logic        pclk_rise, vs_rise, vs_fall, hr_fall, hr_s;
  logic [7:0]  dat_s;

  assign s         = sync_q[SYNC_STAGES-1];
  assign hr_s      = s[8];
  assign dat_s     = s[7:0];
  assign pclk_rise = s[10] & ~last_q[2];
  assign vs_rise   = s[9] & ~last_q[1];
  assign vs_fall   = ~s[9] & last_q[1];
  assign hr_fall   = ~s[8] & last_q[0];

  state_t      state;
  logic        phase;
  logic [7:0]  hi_byte;
  logic        stg_valid;
  logic        stg_sof;
  logic [15:0] stg_data;
  logic        sof_pend;
  logic        push_req;
  logic [17:0] push_word;
`ifdef CAM_CAPTURE_STATS_EN
  logic [11:0] lc_q, pc_q;
  assign line_count  = lc_q;
  assign pixel_count = pc_q;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      phase      <= 1'b0;
      hi_byte    <= '0;
      stg_valid  <= 1'b0;
      stg_sof    <= 1'b0;
      stg_data   <= '0;
      sof_pend   <= 1'b0;
      push_req   <= 1'b0;
      push_word  <= '0;
`ifdef CAM_CAPTURE_STATS_EN
      lc_q       <= '0;
      pc_q       <= '0;
`endif
    end else begin
      push_req   <= 1'b0;
      frame_done <= 1'b0;
      if (!cap_en) begin
        state     <= IDLE;
        busy      <= 1'b0;
        phase     <= 1'b0;
        stg_valid <= 1'b0;
        sof_pend  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: state <= WAIT_VSYNC;
          WAIT_VSYNC: if (vs_rise) begin
            state <= WAIT_FRAME;
            busy  <= 1'b1;
          end
          WAIT_FRAME: if (vs_fall) begin
            state     <= ACTIVE;
            sof_pend  <= 1'b1;
            phase     <= 1'b0;
            stg_valid <= 1'b0;
`ifdef CAM_CAPTURE_STATS_EN
            lc_q      <= '0;
            pc_q      <= '0;
`endif
          end
          ACTIVE: begin
            if (vs_rise || hr_fall) begin
              // Flush the staged pixel as the line's last pixel
              phase     <= 1'b0;
              stg_valid <= 1'b0;
              if (stg_valid) begin
                push_req  <= 1'b1;
                push_word <= {stg_sof, 1'b1, stg_data};
`ifdef CAM_CAPTURE_STATS_EN
                lc_q      <= lc_q + 12'd1;
                pc_q      <= '0;
`endif
              end
              if (vs_rise) begin
                state      <= WAIT_FRAME;
                frame_done <= 1'b1;
              end
            end else if (pclk_rise && hr_s) begin
              phase <= ~phase;
              if (!phase) begin
                hi_byte <= dat_s;
              end else begin
                stg_valid <= 1'b1;
                stg_data  <= {hi_byte, dat_s};
                stg_sof   <= sof_pend;
                sof_pend  <= 1'b0;
                if (stg_valid) begin
                  push_req  <= 1'b1;
                  push_word <= {stg_sof, 1'b0, stg_data};
`ifdef CAM_CAPTURE_STATS_EN
                  pc_q      <= pc_q + 12'd1;
`endif
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic [17:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, wr_ok;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign pix_valid = (count != '0);
  assign pop       = pix_valid & pix_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_ok     = push_req & (~full | pop);
  assign {pix_sof, pix_eol, pix_data} = pix_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge PCLK) begin
    if (wr_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, pop};
      if (!cap_en)
        overflow <= 1'b0;
      else if (push_req && !wr_ok)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: randomized DVP frames checked against a byte-pair pixel model.
// Covers reset, framing, odd bytes, backpressure, full+pop, cap_en drop, mid-frame enable.
module tb_cam_capture;

  localparam int SYNC = 2;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        cap_en = 1'b0;
  logic        cam_pclk = 1'b0;
  logic        cam_vsync = 1'b1;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = '0;
  logic [15:0] pix_data;
  logic        pix_sof, pix_eol, pix_valid;
  logic        pix_ready = 1'b0;
  logic        busy, frame_done, overflow;
`ifdef CAM_CAPTURE_STATS_EN
  logic [11:0] line_count, pixel_count;
`endif

  cam_capture #(.FIFO_DEPTH(16), .SYNC_STAGES(SYNC)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .cap_en(cap_en),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .pix_data(pix_data), .pix_sof(pix_sof),
    .pix_eol(pix_eol), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .busy(busy), .frame_done(frame_done), .overflow(overflow)
`ifdef CAM_CAPTURE_STATS_EN
    , .line_count(line_count), .pixel_count(pixel_count)
`endif
  );

  always #5 PCLK = ~PCLK;
  always #40 cam_pclk = ~cam_pclk;

  int tests = 0;
  int fails = 0;
  int ready_mode = 0;
  int fd_cnt = 0;
  int fd_wide = 0;
  bit fd_prev = 0;
  logic [11:0] lc_at_fd = '0;

  logic [7:0]  fb[$];
  int          ll[$];
  logic [17:0] expq[$];
  logic [17:0] got[$];

  // Ready driver: 0 = stalled, 1 = always ready, 2 = random
  initial forever begin
    @(posedge PCLK);
    #1;
    case (ready_mode)
      0: pix_ready = 1'b0;
      1: pix_ready = 1'b1;
      default: pix_ready = ($urandom % 4) != 0;
    endcase
  end

  always @(negedge PCLK) begin
    if (pix_valid && pix_ready)
      got.push_back({pix_sof, pix_eol, pix_data});
    if (frame_done) begin
      fd_cnt++;
      if (fd_prev) fd_wide++;
`ifdef CAM_CAPTURE_STATS_EN
      lc_at_fd = line_count;
`endif
    end
    fd_prev = frame_done;
  end

  // Reference: each line yields floor(len/2) byte pairs, last one tagged eol,
  // first pixel of the frame tagged sof.
  function automatic void build_exp();
    int off = 0;
    bit first = 1'b1;
    expq.delete();
    foreach (ll[i]) begin
      int np = ll[i] / 2;
      for (int p = 0; p < np; p++) begin
        expq.push_back({first, 1'(p == np - 1), fb[off+2*p], fb[off+2*p+1]});
        first = 1'b0;
      end
      off += ll[i];
    end
  endfunction

  task automatic make_frame(input int nl, input int len, input bit rnd);
    fb.delete();
    ll.delete();
    for (int l = 0; l < nl; l++) begin
      int n = rnd ? int'($urandom_range(0, 12)) : len;
      ll.push_back(n);
      for (int b = 0; b < n; b++) fb.push_back(8'($urandom));
    end
    build_exp();
  endtask

  task automatic cam_line(input int off, input int len);
    if (len > 0) begin
      @(negedge cam_pclk);
      cam_href = 1'b1;
      cam_data = fb[off];
      for (int i = 1; i < len; i++) begin
        @(negedge cam_pclk);
        cam_data = fb[off+i];
      end
      @(negedge cam_pclk);
      cam_href = 1'b0;
      repeat (3) @(negedge cam_pclk);
    end
  endtask

  task automatic send_frame();
    int off = 0;
    repeat (2) @(negedge cam_pclk);
    cam_vsync = 1'b0;
    repeat (2) @(negedge cam_pclk);
    foreach (ll[i]) begin
      cam_line(off, ll[i]);
      off += ll[i];
    end
    cam_vsync = 1'b1;
    repeat (3) @(negedge cam_pclk);
  endtask

  // Enable then give one vsync pulse so the block waits for the next frame
  task automatic enable();
    cap_en = 1'b1;
    repeat (4) @(posedge PCLK);
    @(negedge cam_pclk);
    cam_vsync = 1'b0;
    repeat (2) @(negedge cam_pclk);
    cam_vsync = 1'b1;
    repeat (2) @(negedge cam_pclk);
  endtask

  task automatic wait_drain(input int n);
    for (int i = 0; i < 3000 && got.size() < n; i++) @(negedge PCLK);
    repeat (20) @(negedge PCLK);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge PCLK);
    tests++; if (pix_data !== 16'h0) begin fails++; $display("FAIL reset_data got %h exp 0", pix_data); end
    tests++; if (pix_sof !== 1'b0) begin fails++; $display("FAIL reset_sof got %b exp 0", pix_sof); end
    tests++; if (pix_eol !== 1'b0) begin fails++; $display("FAIL reset_eol got %b exp 0", pix_eol); end
    tests++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", pix_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_fd got %b exp 0", frame_done); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    PRESET = 1'b0;
    repeat (2) @(negedge PCLK);
  endtask

  task automatic test_basic();
    ready_mode = 1;
    make_frame(2, 8, 1'b0);
    fb[0] = 8'h12;
    fb[1] = 8'h34;
    build_exp();
    got.delete();
    fd_cnt = 0;
    enable();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %b exp 1", busy); end
    send_frame();
    wait_drain(expq.size());
    tests++; if (got.size() !== 8) begin fails++; $display("FAIL basic_count got %0d exp 8", got.size()); end
    if (got.size() == 8) begin
      tests++; if (got[0] !== {2'b10, 16'h1234}) begin fails++; $display("FAIL basic_first got %h exp %h", got[0], {2'b10, 16'h1234}); end
      tests++; if (got[3][16] !== 1'b1 || got[7][16] !== 1'b1) begin fails++; $display("FAIL basic_eol got %b%b exp 11", got[3][16], got[7][16]); end
    end
    foreach (expq[i]) if (i < got.size()) begin
      tests++; if (got[i] !== expq[i]) begin fails++; $display("FAIL basic_pix%0d got %h exp %h", i, got[i], expq[i]); end
    end
    tests++; if (fd_cnt !== 1) begin fails++; $display("FAIL basic_fd got %0d exp 1", fd_cnt); end
  endtask

  task automatic test_odd_bytes();
    fb.delete();
    ll.delete();
    for (int i = 0; i < 5; i++) fb.push_back(8'(8'hA1 + i));
    for (int i = 0; i < 4; i++) fb.push_back(8'(8'hB1 + i));
    ll.push_back(5);
    ll.push_back(4);
    build_exp();
    got.delete();
    send_frame();
    wait_drain(expq.size());
    tests++; if (got.size() !== 4) begin fails++; $display("FAIL odd_count got %0d exp 4", got.size()); end
    if (got.size() == 4) begin
      tests++; if (got[1] !== {2'b01, 16'hA3A4}) begin fails++; $display("FAIL odd_eol got %h exp %h", got[1], {2'b01, 16'hA3A4}); end
      tests++; if (got[2][15:0] !== 16'hB1B2) begin fails++; $display("FAIL odd_phase got %h exp b1b2", got[2][15:0]); end
    end
    foreach (expq[i]) if (i < got.size()) begin
      tests++; if (got[i] !== expq[i]) begin fails++; $display("FAIL odd_pix%0d got %h exp %h", i, got[i], expq[i]); end
    end
  endtask

  task automatic test_random_frames();
    ready_mode = 2;
    for (int f = 0; f < 4; f++) begin
      make_frame(int'($urandom_range(1, 4)), 0, 1'b1);
      got.delete();
      fd_cnt = 0;
      send_frame();
      wait_drain(expq.size());
      tests++; if (got.size() !== expq.size()) begin fails++; $display("FAIL rand%0d_count got %0d exp %0d", f, got.size(), expq.size()); end
      foreach (expq[i]) if (i < got.size()) begin
        tests++; if (got[i] !== expq[i]) begin fails++; $display("FAIL rand%0d_pix%0d got %h exp %h", f, i, got[i], expq[i]); end
      end
      tests++; if (fd_cnt !== 1) begin fails++; $display("FAIL rand%0d_fd got %0d exp 1", f, fd_cnt); end
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] h;
    ready_mode = 0;
    repeat (4) @(negedge PCLK);
    make_frame(1, 40, 1'b0);
    got.delete();
    send_frame();
    @(negedge PCLK);
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL bp_ovf got %b exp 1", overflow); end
    h = {pix_sof, pix_eol, pix_data};
    tests++; if (h !== expq[0]) begin fails++; $display("FAIL bp_head got %h exp %h", h, expq[0]); end
    repeat (5) @(negedge PCLK);
    tests++; if ({pix_sof, pix_eol, pix_data} !== h || pix_valid !== 1'b1) begin
      fails++; $display("FAIL bp_stable got %h exp %h", {pix_sof, pix_eol, pix_data}, h);
    end
    ready_mode = 1;
    wait_drain(16);
    tests++; if (got.size() !== 16) begin fails++; $display("FAIL bp_count got %0d exp 16", got.size()); end
    for (int i = 0; i < 16; i++) if (i < got.size()) begin
      tests++; if (got[i] !== expq[i]) begin fails++; $display("FAIL bp_pix%0d got %h exp %h", i, got[i], expq[i]); end
    end
    cap_en = 1'b0;
    repeat (3) @(negedge PCLK);
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL bp_ovf_clr got %b exp 0", overflow); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_full_pop();
    ready_mode = 0;
    enable();
    make_frame(1, 34, 1'b0);
    got.delete();
    @(negedge cam_pclk);
    cam_vsync = 1'b0;
    repeat (2) @(negedge cam_pclk);
    cam_href = 1'b1;
    cam_data = fb[0];
    for (int i = 1; i < 34; i++) begin
      @(negedge cam_pclk);
      cam_data = fb[i];
    end
    @(negedge cam_pclk);
    cam_href = 1'b0;
    // Release ready so the first pop lands on the eol push into the full FIFO
    repeat (SYNC + 1) @(posedge PCLK);
    ready_mode = 1;
    repeat (3) @(negedge cam_pclk);
    cam_vsync = 1'b1;
    repeat (3) @(negedge cam_pclk);
    wait_drain(17);
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fp_ovf got %b exp 0", overflow); end
    tests++; if (got.size() !== 17) begin fails++; $display("FAIL fp_count got %0d exp 17", got.size()); end
    foreach (expq[i]) if (i < got.size()) begin
      tests++; if (got[i] !== expq[i]) begin fails++; $display("FAIL fp_pix%0d got %h exp %h", i, got[i], expq[i]); end
    end
  endtask

  task automatic test_cap_drop();
    int eols = 0;
    ready_mode = 0;
    make_frame(1, 12, 1'b0);
    got.delete();
    fd_cnt = 0;
    @(negedge cam_pclk);
    cam_vsync = 1'b0;
    repeat (2) @(negedge cam_pclk);
    cam_href = 1'b1;
    cam_data = fb[0];
    for (int i = 1; i < 12; i++) begin
      @(negedge cam_pclk);
      cam_data = fb[i];
      if (i == 8) begin
        #12;
        cap_en = 1'b0;
      end
    end
    @(negedge cam_pclk);
    cam_href = 1'b0;
    repeat (3) @(negedge cam_pclk);
    cam_vsync = 1'b1;
    repeat (3) @(negedge cam_pclk);
    @(negedge PCLK);
    tests++; if (busy !== 1'b0 || pix_valid !== 1'b1) begin fails++; $display("FAIL drop_state got busy=%b valid=%b exp 0 1", busy, pix_valid); end
    ready_mode = 1;
    wait_drain(3);
    tests++; if (got.size() !== 3) begin fails++; $display("FAIL drop_count got %0d exp 3", got.size()); end
    foreach (got[i]) if (i < 3) begin
      eols += int'(got[i][16]);
      tests++; if (got[i] !== expq[i]) begin fails++; $display("FAIL drop_pix%0d got %h exp %h", i, got[i], expq[i]); end
    end
    tests++; if (eols !== 0) begin fails++; $display("FAIL drop_eol got %0d exp 0", eols); end
    tests++; if (fd_cnt !== 0) begin fails++; $display("FAIL drop_fd got %0d exp 0", fd_cnt); end
  endtask

  task automatic test_mid_enable();
    ready_mode = 1;
    make_frame(2, 6, 1'b0);
    got.delete();
    fd_cnt = 0;
    @(negedge cam_pclk);
    cam_vsync = 1'b0;
    repeat (2) @(negedge cam_pclk);
    cam_line(0, 6);
    cap_en = 1'b1;
    cam_line(6, 6);
    cam_vsync = 1'b1;
    repeat (3) @(negedge cam_pclk);
    repeat (20) @(negedge PCLK);
    tests++; if (got.size() !== 0 || fd_cnt !== 0) begin fails++; $display("FAIL mid_partial got %0d pix %0d fd exp 0 0", got.size(), fd_cnt); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy got %b exp 1", busy); end
    make_frame(2, 8, 1'b0);
    send_frame();
    wait_drain(expq.size());
    tests++; if (got.size() !== expq.size()) begin fails++; $display("FAIL mid_count got %0d exp %0d", got.size(), expq.size()); end
    foreach (expq[i]) if (i < got.size()) begin
      tests++; if (got[i] !== expq[i]) begin fails++; $display("FAIL mid_pix%0d got %h exp %h", i, got[i], expq[i]); end
    end
    tests++; if (fd_cnt !== 1) begin fails++; $display("FAIL mid_fd got %0d exp 1", fd_cnt); end
  endtask

`ifdef CAM_CAPTURE_STATS_EN
  task automatic test_stats();
    ready_mode = 1;
    make_frame(3, 8, 1'b0);
    got.delete();
    send_frame();
    wait_drain(expq.size());
    tests++; if (lc_at_fd !== 12'd3) begin fails++; $display("FAIL stats_lc got %0d exp 3", lc_at_fd); end
    tests++; if (line_count !== 12'd3) begin fails++; $display("FAIL stats_hold got %0d exp 3", line_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_odd_bytes();
    test_random_frames();
    test_backpressure();
    test_full_pop();
    test_cap_drop();
    test_mid_enable();
`ifdef CAM_CAPTURE_STATS_EN
    test_stats();
`endif
    tests++; if (fd_wide !== 0) begin fails++; $display("FAIL fd_width got %0d wide pulses exp 0", fd_wide); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
